// File: rtl/riscv_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one ibus read at a time and
// hands each fetched word to decode over valid/ready, squashing wrong-path responses.
module riscv_fetch_ctrl #(
    parameter int                         IBUS_DATA_WIDTH = 32,
    parameter int                         IBUS_ADDR_WIDTH = 64,
    parameter logic [IBUS_ADDR_WIDTH-1:0] RESET_PC        = 'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ibus_req,
    output logic [IBUS_ADDR_WIDTH-1:0] ibus_addr,
    input  logic                       ibus_gnt,
    input  logic                       ibus_rvalid,
    input  logic [IBUS_DATA_WIDTH-1:0] ibus_rdata,
    input  logic                       ibus_err,
    input  logic                       redirect_valid,
    input  logic [IBUS_ADDR_WIDTH-1:0] redirect_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [IBUS_DATA_WIDTH-1:0] instr,
    output logic [IBUS_ADDR_WIDTH-1:0] instr_pc,
    output logic                       instr_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    localparam logic [IBUS_ADDR_WIDTH-1:0] RESET_PC_ALIGNED =
        {RESET_PC[IBUS_ADDR_WIDTH-1:2], 2'b00};

    state_t                       state, state_d;
    logic [IBUS_ADDR_WIDTH-1:0]   pc, pc_d;
    logic [IBUS_ADDR_WIDTH-1:0]   addr, addr_d;
    logic                         drop, drop_d;
    logic                         valid_d;
    logic [IBUS_DATA_WIDTH-1:0]   instr_d;
    logic [IBUS_ADDR_WIDTH-1:0]   instr_pc_d;
    logic                         fault_d;
    logic [IBUS_ADDR_WIDTH-1:0]   redirect_aligned;
    logic                         unused_redirect_lsbs;

    assign redirect_aligned     = {redirect_pc[IBUS_ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign ibus_req  = (state == REQ);
    assign ibus_addr = addr;

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        addr_d     = addr;
        drop_d     = drop;
        valid_d    = instr_valid;
        instr_d    = instr;
        instr_pc_d = instr_pc;
        fault_d    = instr_fault;

        if (redirect_valid) begin
            pc_d    = redirect_aligned;
            valid_d = 1'b0;
            unique case (state)
                IDLE, HOLD: state_d = REQ;
                REQ: begin
                    drop_d = 1'b1;
                    if (ibus_gnt) state_d = WAIT;
                end
                WAIT: begin
                    if (ibus_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state)
                IDLE: state_d = REQ;
                REQ:  if (ibus_gnt) state_d = WAIT;
                WAIT: begin
                    if (ibus_rvalid) begin
                        if (drop) begin
                            drop_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            instr_d    = ibus_err ? '0 : ibus_rdata;
                            fault_d    = ibus_err;
                            instr_pc_d = pc;
                            pc_d       = pc + IBUS_ADDR_WIDTH'(4);
                            valid_d    = 1'b1;
                            state_d    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end

        // The address is latched only on entry to REQ so it stays put across gnt stalls.
        if (state_d == REQ && state != REQ) addr_d = pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC_ALIGNED;
            addr        <= RESET_PC_ALIGNED;
            drop        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_fault <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            addr        <= addr_d;
            drop        <= drop_d;
            instr_valid <= valid_d;
            instr       <= instr_d;
            instr_pc    <= instr_pc_d;
            instr_fault <= fault_d;
        end
    end

`ifndef SYNTHESIS
    a_rvalid_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        ibus_rvalid |-> (state == WAIT));

    a_addr_stable_in_stall: assert property (@(posedge clk) disable iff (rst)
        (ibus_req && !ibus_gnt) |=> $stable(ibus_addr));
`endif

endmodule
